// File: rtl/parity_xor_pipe.sv
// parity_xor_pipe: two-stage pipelined per-lane y = a ^ b ^ (c & d) with valid/ready handshakes.
// Optional macro PARITY_ERR_CNT_EN adds err_clr/err_cnt, a saturating count of delivered words with out_all=0.
module parity_xor_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_c,
    input  logic [WIDTH-1:0] in_d,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_all
`ifdef PARITY_ERR_CNT_EN
    ,
    input  logic             err_clr,
    output logic [CNT_W-1:0] err_cnt
`endif
);
    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_x;
    logic [WIDTH-1:0] r_s1_n;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_y;
    logic             r_out_all;
    logic             w_s2_adv;
    logic             w_s1_adv;
    logic [WIDTH-1:0] w_y;

    assign w_s2_adv  = !r_out_valid || out_ready;
    assign w_s1_adv  = !r_s1_valid || w_s2_adv;
    assign w_y       = r_s1_x ^ r_s1_n;
    assign in_ready  = w_s1_adv;
    assign out_valid = r_out_valid;
    assign out_y     = r_out_y;
    assign out_all   = r_out_all;

    // stage 1: capture a^b and c&d whenever the stage can advance
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_x     <= '0;
            r_s1_n     <= '0;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_x <= in_a ^ in_b;
                r_s1_n <= in_c & in_d;
            end
        end
    end

    // stage 2: combine into the result and its AND-reduction; holds while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_y     <= '0;
            r_out_all   <= 1'b0;
        end else if (w_s2_adv) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_y   <= w_y;
                r_out_all <= &w_y;
            end
        end
    end

`ifdef PARITY_ERR_CNT_EN
    logic [CNT_W-1:0] r_err_cnt;
    assign err_cnt = r_err_cnt;

    // count delivered mismatches, saturating; clear wins over a same-cycle increment
    always_ff @(posedge clk) begin
        if (rst || err_clr)
            r_err_cnt <= '0;
        else if (r_out_valid && out_ready && !r_out_all && r_err_cnt != {CNT_W{1'b1}})
            r_err_cnt <= r_err_cnt + 1'b1;
    end
`endif
endmodule
